// File: rtl/hdmi_i2c_cfg_seq.sv
// HDMI transmitter SCCB/I2C configuration sequencer.
// Walks a register table after power-up settle, one byte write per entry.
module hdmi_i2c_cfg_seq #(
  parameter int LUT_SIZE       = 32,
  parameter int IDX_W          = 6,
  parameter int INIT_DELAY     = 1_000_000,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] lut_index,
  input  logic [23:0]      lut_data,
  output logic             wr_req,
  output logic [7:0]       wr_dev,
  output logic [7:0]       wr_reg,
  output logic [7:0]       wr_data,
  input  logic             wr_ack,
  input  logic             wr_done,
  input  logic             wr_nack,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] err_index
);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);
  localparam logic [31:0] INIT_END  = 32'(INIT_DELAY - 1);
  localparam logic [31:0] GAP_END   = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_END   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       retry;
  logic             refetch;

  logic wr_ok;
  logic wr_fail;
  logic retry_out;
  logic idle;
  logic restart;

  // wr_done wins over a timeout landing on the same cycle
  assign wr_ok     = (state_q == S_WAIT_DONE) && wr_done && !wr_nack;
  assign wr_fail   = (state_q == S_WAIT_DONE) &&
                     (wr_done ? wr_nack : (cnt == TMO_END));
  assign retry_out = (retry + 8'd1) >= RETRY_MAX;
  assign idle      = (state_q == S_DONE) || (state_q == S_ERROR);
  assign restart   = start && idle;
  assign busy      = !idle;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_PWR_WAIT;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PWR_WAIT:
        if (cnt == INIT_END) state_d = S_FETCH;
      S_FETCH:
        state_d = S_LATCH;
      S_LATCH:
        state_d = (lut_data[23:16] == 8'hFF) ? S_DONE : S_ISSUE;
      S_ISSUE:
        if (wr_ack) state_d = S_WAIT_DONE;
      S_WAIT_DONE:
        if (wr_ok)
          state_d = (idx == LAST_IDX) ? S_DONE : S_GAP;
        else if (wr_fail)
          state_d = retry_out ? S_ERROR : S_GAP;
      S_GAP:
        if (cnt == GAP_END)
          state_d = refetch ? S_FETCH : S_ISSUE;
      S_DONE,
      S_ERROR:
        if (start) state_d = S_FETCH;
      default:
        state_d = S_PWR_WAIT;
    endcase
  end

  // Counters, table pointer, retry tracking and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      retry     <= '0;
      refetch   <= 1'b0;
      lut_index <= '0;
      wr_req    <= 1'b0;
      wr_dev    <= '0;
      wr_reg    <= '0;
      wr_data   <= '0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_index <= '0;
    end else begin
      cnt      <= (state_d != state_q) ? '0 : cnt + 32'd1;
      wr_req   <= (state_d == S_ISSUE);
      cfg_done <= (state_d == S_DONE);
      cfg_err  <= (state_d == S_ERROR);
      if (state_q == S_LATCH)
        {wr_dev, wr_reg, wr_data} <= lut_data;
      if (restart) begin
        idx       <= '0;
        retry     <= '0;
        lut_index <= '0;
      end else if (state_d == S_FETCH) begin
        lut_index <= idx;
      end
      if (wr_ok) begin
        idx     <= idx + 1'b1;
        retry   <= '0;
        refetch <= 1'b1;
      end else if (wr_fail) begin
        retry   <= retry + 8'd1;
        refetch <= 1'b0;
        if (retry_out) err_index <= idx;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// Directed bench for hdmi_i2c_cfg_seq.
// Models the table ROM and a scripted SCCB write engine.
module tb_hdmi_i2c_cfg_seq;

  localparam int IDX_W = 6;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [IDX_W-1:0] lut_index;
  logic [23:0]      lut_data;
  logic             wr_req;
  logic [7:0]       wr_dev;
  logic [7:0]       wr_reg;
  logic [7:0]       wr_data;
  logic             wr_ack;
  logic             wr_done;
  logic             wr_nack;
  logic             busy;
  logic             cfg_done;
  logic             cfg_err;
  logic [IDX_W-1:0] err_index;

  int n_run;
  int n_fail;
  int cyc;
  int rel_cyc;
  int s_cyc;
  int nack_cyc;

  logic [23:0] rom [64];
  logic [23:0] log_w [64];
  int          log_cyc [64];
  int          n_wr;
  int          nack_plan [8];
  bit          nodone_plan [8];
  int          eng_ok;
  int          eng_att;
  int          eng_e;
  int          max_idx;
  bit          bad_busy;
  logic [IDX_W-1:0] ri;

  hdmi_i2c_cfg_seq #(
    .LUT_SIZE      (8),
    .IDX_W         (IDX_W),
    .INIT_DELAY    (16),
    .GAP_CYCLES    (4),
    .TIMEOUT_CYCLES(64),
    .MAX_RETRY     (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .lut_index(lut_index),
    .lut_data (lut_data),
    .wr_req   (wr_req),
    .wr_dev   (wr_dev),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .wr_done  (wr_done),
    .wr_nack  (wr_nack),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .err_index(err_index)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Synchronous ROM: data for the index seen this cycle appears after the edge
  initial begin
    lut_data = '0;
    forever begin
      @(negedge clk);
      ri = lut_index;
      @(posedge clk);
      #1 lut_data = rom[ri];
    end
  end

  initial begin
    max_idx = 0;
    forever begin
      @(negedge clk);
      if (int'(lut_index) > max_idx) max_idx = int'(lut_index);
    end
  end

  // Write engine: ack 2 cycles after seeing a request, done 10 later
  initial begin
    wr_ack  = 1'b0;
    wr_done = 1'b0;
    wr_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && wr_req) begin
        if (n_wr < 64) begin
          log_w[n_wr]   = {wr_dev, wr_reg, wr_data};
          log_cyc[n_wr] = cyc;
        end
        n_wr++;
        repeat (2) @(negedge clk);
        if (!wr_req) continue;
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        eng_e = (eng_ok > 7) ? 7 : eng_ok;
        if (nodone_plan[eng_e]) continue;
        repeat (10) @(negedge clk);
        if (!rst_n) continue;
        wr_done = 1'b1;
        wr_nack = (eng_att < nack_plan[eng_e]);
        if (wr_nack) begin
          nack_cyc = cyc;
          eng_att++;
        end else begin
          eng_ok++;
          eng_att = 0;
        end
        @(negedge clk);
        wr_done = 1'b0;
        wr_nack = 1'b0;
      end
    end
  end

  task automatic clr_eng();
    n_wr    = 0;
    eng_ok  = 0;
    eng_att = 0;
    max_idx = 0;
    bad_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      nack_plan[i]   = 0;
      nodone_plan[i] = 1'b0;
    end
  endtask

  task automatic load_tbl(input int nv);
    for (int i = 0; i < 64; i++) rom[i] = 24'hFF0000;
    for (int i = 0; i < nv && i < 8; i++)
      rom[i] = {8'h72, 8'(8'h20 + 8 * i), 8'(i + 1)};
    if (nv > 0) rom[0] = 24'h724110;
    if (nv > 1) rom[1] = 24'h729803;
    if (nv > 2) rom[2] = 24'h72AF16;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int k;
    k = 0;
    while (!(cfg_done || cfg_err) && k < 3000) begin
      @(negedge clk);
      k++;
      if (busy !== !(cfg_done || cfg_err)) bad_busy = 1'b1;
    end
    n_run++;
    if (!(cfg_done || cfg_err)) begin
      n_fail++;
      $display("FAIL %s_end: no done/err after %0d cycles", nm, k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    clr_eng();
    load_tbl(3);
    repeat (3) @(negedge clk);
    n_run++;
    if (wr_req !== 1'b0 || lut_index !== '0) begin
      n_fail++;
      $display("FAIL rst_req_idx: got %b/%0d want 0/0", wr_req, lut_index);
    end
    n_run++;
    if ({wr_dev, wr_reg, wr_data} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_fields: got %h want 000000",
               {wr_dev, wr_reg, wr_data});
    end
    n_run++;
    if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || err_index !== '0) begin
      n_fail++;
      $display("FAIL rst_status: got %b%b/%0d want 00/0",
               cfg_done, cfg_err, err_index);
    end
    n_run++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 1", busy);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_run++;
    if (wr_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pwr_wait: req/busy %b/%b want 0/1", wr_req, busy);
    end
  endtask

  task automatic test_basic();
    clr_eng();
    load_tbl(3);
    do_reset();
    wait_end("basic");
    n_run++;
    if (n_wr !== 3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 3", n_wr);
    end
    n_run++;
    if (log_w[0] !== 24'h724110 || log_w[1] !== 24'h729803 ||
        log_w[2] !== 24'h72AF16) begin
      n_fail++;
      $display("FAIL basic_fields: got %h %h %h want 724110 729803 72af16",
               log_w[0], log_w[1], log_w[2]);
    end
    n_run++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: done/err/busy %b%b%b want 100",
               cfg_done, cfg_err, busy);
    end
    n_run++;
    if (lut_index !== 6'd3) begin
      n_fail++;
      $display("FAIL basic_lastidx: got %0d want 3", lut_index);
    end
    n_run++;
    if (log_cyc[0] - rel_cyc < 18) begin
      n_fail++;
      $display("FAIL basic_initwait: first req at %0d want >=18",
               log_cyc[0] - rel_cyc);
    end
    n_run++;
    if (bad_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy disagreed with done/err (%b want 0)",
               bad_busy);
    end
  endtask

  task automatic test_nack_once();
    clr_eng();
    load_tbl(3);
    nack_plan[1] = 1;
    do_reset();
    wait_end("nack1");
    n_run++;
    if (n_wr !== 4) begin
      n_fail++;
      $display("FAIL nack1_count: got %0d want 4", n_wr);
    end
    n_run++;
    if (log_w[1] !== 24'h729803 || log_w[2] !== 24'h729803 ||
        log_w[3] !== 24'h72AF16) begin
      n_fail++;
      $display("FAIL nack1_fields: got %h %h %h want 729803 729803 72af16",
               log_w[1], log_w[2], log_w[3]);
    end
    n_run++;
    if (log_cyc[2] - nack_cyc !== 5) begin
      n_fail++;
      $display("FAIL nack1_gap: done-to-req %0d want 5",
               log_cyc[2] - nack_cyc);
    end
    n_run++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nack1_status: done/err %b%b want 10", cfg_done, cfg_err);
    end
  endtask

  task automatic test_nack_always();
    clr_eng();
    load_tbl(6);
    nack_plan[2] = 99;
    do_reset();
    wait_end("nackall");
    n_run++;
    if (n_wr !== 5 || log_w[4] !== rom[2]) begin
      n_fail++;
      $display("FAIL nackall_count: got %0d/%h want 5/%h",
               n_wr, log_w[4], rom[2]);
    end
    n_run++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || err_index !== 6'd2) begin
      n_fail++;
      $display("FAIL nackall_status: err/done/idx %b%b/%0d want 10/2",
               cfg_err, cfg_done, err_index);
    end
    n_run++;
    if (max_idx !== 2) begin
      n_fail++;
      $display("FAIL nackall_maxidx: got %0d want 2", max_idx);
    end
  endtask

  task automatic test_timeout_restart();
    clr_eng();
    load_tbl(3);
    nodone_plan[0] = 1'b1;
    do_reset();
    wait_end("tmo");
    n_run++;
    if (n_wr !== 3 || cfg_err !== 1'b1 || err_index !== 6'd0) begin
      n_fail++;
      $display("FAIL tmo_status: writes/err/idx %0d/%b/%0d want 3/1/0",
               n_wr, cfg_err, err_index);
    end
    n_run++;
    if (log_cyc[1] - log_cyc[0] !== 71) begin
      n_fail++;
      $display("FAIL tmo_spacing: got %0d want 71",
               log_cyc[1] - log_cyc[0]);
    end
    clr_eng();
    pulse_start();
    wait_end("restart");
    n_run++;
    if (n_wr !== 3 || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_status: writes/done/err %0d/%b%b want 3/10",
               n_wr, cfg_done, cfg_err);
    end
    n_run++;
    if (log_cyc[0] - s_cyc !== 3 || log_w[0] !== 24'h724110) begin
      n_fail++;
      $display("FAIL restart_nowait: lat %0d fld %h want 3 724110",
               log_cyc[0] - s_cyc, log_w[0]);
    end
  endtask

  task automatic test_full_table();
    clr_eng();
    load_tbl(8);
    do_reset();
    wait_end("full");
    n_run++;
    if (n_wr !== 8 || cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL full_count: writes/done %0d/%b want 8/1", n_wr, cfg_done);
    end
    n_run++;
    if (log_w[7] !== 24'h725808) begin
      n_fail++;
      $display("FAIL full_last: got %h want 725808", log_w[7]);
    end
    n_run++;
    if (max_idx > 7) begin
      n_fail++;
      $display("FAIL full_maxidx: got %0d want <=7", max_idx);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    bit hit;
    clr_eng();
    load_tbl(8);
    do_reset();
    hit = 1'b0;
    k = 0;
    while (!hit && k < 3000) begin
      @(negedge clk);
      #2;
      k++;
      if (wr_req && n_wr == 5) hit = 1'b1;
    end
    n_run++;
    if (!hit || log_w[4] !== rom[4]) begin
      n_fail++;
      $display("FAIL mid_reach: hit %b fld %h want 1 %h", hit, log_w[4], rom[4]);
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if (wr_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_drop: req/busy %b/%b want 0/1", wr_req, busy);
    end
    repeat (4) @(negedge clk);
    clr_eng();
    rst_n = 1'b1;
    rel_cyc = cyc;
    repeat (30) @(negedge clk);
    pulse_start();
    wait_end("mid");
    n_run++;
    if (n_wr !== 8 || cfg_done !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_count: writes/done %0d/%b want 8/1", n_wr, cfg_done);
    end
    n_run++;
    if (log_w[0] !== 24'h724110 || log_cyc[0] - rel_cyc !== 18) begin
      n_fail++;
      $display("FAIL mid_first: fld %h lat %0d want 724110 18",
               log_w[0], log_cyc[0] - rel_cyc);
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    nack_cyc = 0;
    s_cyc = 0;
    rel_cyc = 0;
    test_reset();
    test_basic();
    test_nack_once();
    test_nack_always();
    test_timeout_restart();
    test_full_table();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_i2c_cfg_seq.md
Name: hdmi_i2c_cfg_seq

Overview:
Configuration sequencer for the HDMI transmitter's SCCB/I2C control port. After power-up it waits a settle delay, then walks a register table and issues one byte-write transaction per entry to the byte-level SCCB write engine. Each transaction is handshaked, timed out and retried on NACK. The block reports done or error to the video pipeline, which holds off output until `cfg_done` is high.

Parameters:
- LUT_SIZE, 32: number of table entries (index range 0..LUT_SIZE-1).
- IDX_W, 6: width of `lut_index` and `err_index`.
- INIT_DELAY, 1_000_000: clk cycles of power-up settle wait before the first write.
- GAP_CYCLES, 1000: idle cycles between consecutive transactions, including retries.
- TIMEOUT_CYCLES, 200_000: cycles allowed from `wr_ack` to `wr_done` before the write counts as failed.
- MAX_RETRY, 3: attempts per entry before declaring error.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse that re-runs the table from index 0. Honoured only in DONE or ERROR.
- lut_index, out, IDX_W: address to the synchronous register table ROM.
- lut_data, in, 24: {dev_addr[7:0], reg_addr[7:0], reg_data[7:0]}, valid 1 cycle after `lut_index`. dev_addr 8'hFF marks end of table.
- wr_req, out, 1: write request to the SCCB engine.
- wr_dev, out, 8: device write address.
- wr_reg, out, 8: register address.
- wr_data, out, 8: register data.
- wr_ack, in, 1: engine accepted the request.
- wr_done, in, 1: single-cycle pulse when the transaction finishes.
- wr_nack, in, 1: qualified by `wr_done`; 1 means the slave did not acknowledge.
- busy, out, 1: high in every state except DONE and ERROR.
- cfg_done, out, 1: table completed successfully.
- cfg_err, out, 1: an entry exhausted its retries.
- err_index, out, IDX_W: index of the failing entry. Valid while `cfg_err` is high.

Behaviour:
- Reset state is PWR_WAIT, with all counters at 0. Reset values: `wr_req`=0, `wr_dev`/`wr_reg`/`wr_data`=0, `lut_index`=0, `cfg_done`=0, `cfg_err`=0, `err_index`=0. `busy` is decoded from state, so it reads 1 while in reset.
- Assertion of `rst_n` mid-transaction:
  - drops `wr_req` immediately;
  - returns the block to PWR_WAIT;
  - causes the full INIT_DELAY to be served again.
- PWR_WAIT: counts INIT_DELAY cycles, then goes to FETCH.
- FETCH (1 cycle): drives `lut_index` = idx, then goes to LATCH.
- LATCH (1 cycle): captures `lut_data` into `wr_dev`/`wr_reg`/`wr_data`.
  - If dev_addr==8'hFF, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: holds `wr_req`=1 with the captured fields stable until `wr_ack` is sampled 1. `wr_req` drops the following cycle; go to WAIT_DONE. There is no timeout on `wr_ack`.
- WAIT_DONE: runs the timeout counter.
  - `wr_done` with `wr_nack`=0 is success: retry count cleared, idx incremented.
  - If idx was LUT_SIZE-1, go to DONE. Otherwise go to GAP, then FETCH.
  - `wr_done` with `wr_nack`=1, or the counter reaching TIMEOUT_CYCLES, is a failure: retry count incremented.
  - If the new count is below MAX_RETRY, go to GAP, then ISSUE with the same latched fields (no refetch).
  - Otherwise go to ERROR with `err_index`=idx.
  - If `wr_done` arrives on the same cycle the timeout expires, `wr_done` wins.
- `wr_done`/`wr_nack` outside WAIT_DONE are ignored.
- GAP: waits GAP_CYCLES cycles.
- DONE: `cfg_done`=1, held. `start` clears it, sets idx and retry count to 0, and goes to FETCH; no power wait.
- ERROR: `cfg_err`=1, held. `start` clears it and restarts as from DONE.
- `start` in any other state has no effect.
- All outputs are registered; `busy` is decoded directly from the state register.
- Success path latency per entry: 2 (FETCH+LATCH) + ack wait + engine time + GAP_CYCLES.

Test Plan:
(Bench overrides: INIT_DELAY=16, GAP_CYCLES=4, TIMEOUT_CYCLES=64, MAX_RETRY=3, LUT_SIZE=8.)
1. Table of 3 entries, then 8'hFF at index 3; engine acks after 2 cycles and done/no-nack after 10 → exactly 3 writes in order, e.g. {72,41,10},{72,98,03},{72,AF,16}. `cfg_done` rises after index 3 is latched. `busy` falls the same cycle. First `wr_req` is no earlier than cycle 16+2 after reset release.
2. Entry 1 NACKs once, then succeeds → entry 1 issued twice with identical fields and a 4-cycle gap between attempts; run ends `cfg_done`=1, `cfg_err`=0.
3. Entry 2 NACKs on every attempt → exactly 3 attempts; `cfg_err`=1, `err_index`=2; no writes for entries 3+.
4. Engine never pulses `wr_done` for entry 0 → timeout after 64 cycles on each of 3 attempts, then ERROR with `err_index`=0. Then `start` with a healthy engine → full table runs and `cfg_done`=1.
5. Table of 8 valid entries with no FF marker → 8 writes, DONE after idx 7. `lut_index` never exceeds 7.
6. Pulse `rst_n` low while `wr_req`=1 for entry 4 → `wr_req`=0 within reset. After release: 16-cycle wait, then the first write is entry 0. A `start` pulse during the run is ignored (write count unchanged).
